digits_to_score: RTL and testbench

Sequential decimal-to-binary converter: accepts a 7-digit BCD score (d6 = millions … d0 = ones) and returns the 20-bit binary score (0–1,000,000) with a start/done handshake. It is the inverse of the score-to-digits display path. The game-logic side uses it to load decimal values, such as stored high scores or preset targets, back into binary score registers. Conversion is iterative: one digit per clock, multiply-accumulate by 10.

---
 rtl/digits_to_score_if.sv | 26 ++
 rtl/digits_to_score.sv | 89 ++++++++
 tb/tb_digits_to_score.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/digits_to_score_if.sv
// Handshake and data bundle between the game logic and the BCD-to-binary score converter.
// The master drives start and the seven BCD digits; the converter answers with busy/done/score/err.
interface digits_to_score_if;
    logic        start;
    logic [3:0]  d6;
    logic [3:0]  d5;
    logic [3:0]  d4;
    logic [3:0]  d3;
    logic [3:0]  d2;
    logic [3:0]  d1;
    logic [3:0]  d0;
    logic        busy;
    logic        done;
    logic [19:0] score;
    logic        err;

    modport master (
        output start, d6, d5, d4, d3, d2, d1, d0,
        input  busy, done, score, err
    );

    modport slave (
        input  start, d6, d5, d4, d3, d2, d1, d0,
        output busy, done, score, err
    );
endinterface

// File: rtl/digits_to_score.sv
// Iterative 7-digit BCD to 20-bit binary converter: one digit per clock, multiply-accumulate by 10,
// constant 8-clock latency from accept to a one-cycle done pulse.
module digits_to_score (
    input  logic             clk,
    input  logic             rst_n,
    digits_to_score_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

    localparam logic [23:0] SCORE_MAX = 24'd1000000;

    state_t      state;
    logic [27:0] dig;
    logic [23:0] acc;
    logic [2:0]  cnt;
    logic        bad;
    logic        busy;
    logic        done;
    logic [19:0] score;
    logic        err;
    logic [3:0]  cur;
    logic        fin_err;

    // acc*10 + digit without a multiplier; 24 bits cannot overflow even with seven 4'hF digits.
    function automatic logic [23:0] mac10(input logic [23:0] a, input logic [3:0] d);
        mac10 = (a << 3) + (a << 1) + {20'd0, d};
    endfunction

    function automatic logic out_of_range(input logic [23:0] a);
        out_of_range = (a > SCORE_MAX);
    endfunction

    assign cur     = dig[27:24];
    assign fin_err = bad | out_of_range(acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dig   <= '0;
            acc   <= '0;
            cnt   <= '0;
            bad   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            score <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        dig   <= {bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
                        acc   <= '0;
                        cnt   <= '0;
                        bad   <= 1'b0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    acc <= mac10(acc, cur);
                    bad <= bad | (cur > 4'd9);
                    dig <= {dig[23:0], 4'd0};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd6) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    err   <= fin_err;
                    score <= fin_err ? 20'd0 : acc[19:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.score = score;
    assign bus.err   = err;
endmodule

// File: tb/tb_digits_to_score.sv
// Directed and random-vector bench for digits_to_score; expected scores are hand-computed or
// derived from the positional sum of the digits.
module tb_digits_to_score;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    digits_to_score_if bus ();

    digits_to_score dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic set_digits(input logic [27:0] v);
        bus.d6 = v[27:24];
        bus.d5 = v[23:20];
        bus.d4 = v[19:16];
        bus.d3 = v[15:12];
        bus.d2 = v[11:8];
        bus.d1 = v[7:4];
        bus.d0 = v[3:0];
    endtask

    // Issue one start pulse and observe the conversion; lat = clocks from accept to done (99 = no done).
    task automatic convert(input logic [27:0] v, output int lat, output int busy_cycles,
                           output logic busy_at_done, output logic [19:0] sc, output logic e,
                           output logic overlap);
        @(negedge clk);
        set_digits(v);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        busy_cycles  = bus.busy ? 1 : 0;
        lat          = 99;
        overlap      = 1'b0;
        busy_at_done = 1'b0;
        sc           = 20'hxxxxx;
        e            = 1'bx;
        for (int i = 1; i <= 20 && lat == 99; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy && bus.done) overlap = 1'b1;
            if (bus.done) begin
                lat          = i;
                busy_at_done = bus.busy;
                sc           = bus.score;
                e            = bus.err;
            end else if (bus.busy) begin
                busy_cycles++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        set_digits(28'h0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.score !== 20'd0) begin errors++; $display("FAIL reset_score: got %h want 0", bus.score); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat, bc;
        logic bad_, e, ov;
        logic [19:0] sc;
        convert(28'h1000000, lat, bc, bad_, sc, e, ov);
        checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
        checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
        checks++; if (bad_ !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", bad_); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL basic_busy_done_overlap: got %b want 0", ov); end
        checks++; if (sc !== 20'hF4240) begin errors++; $display("FAIL basic_score: got %h want f4240", sc); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", e); end
        @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", bus.done); end
        checks++; if (bus.score !== 20'hF4240) begin errors++; $display("FAIL basic_score_hold: got %h want f4240", bus.score); end
    endtask

    task automatic test_values;
        int lat, bc;
        logic bad_, e, ov;
        logic [19:0] sc;
        convert(28'h0999999, lat, bc, bad_, sc, e, ov);
        checks++; if (lat !== 8) begin errors++; $display("FAIL v999999_latency: got %0d want 8", lat); end
        checks++; if (sc !== 20'hF423F) begin errors++; $display("FAIL v999999_score: got %h want f423f", sc); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL v999999_err: got %b want 0", e); end
        convert(28'h0000000, lat, bc, bad_, sc, e, ov);
        checks++; if (sc !== 20'd0) begin errors++; $display("FAIL zero_score: got %h want 0", sc); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL zero_err: got %b want 0", e); end
    endtask

    task automatic test_errors;
        int lat, bc;
        logic bad_, e, ov;
        logic [19:0] sc;
        convert(28'h0999999, lat, bc, bad_, sc, e, ov);
        checks++; if (sc !== 20'hF423F) begin errors++; $display("FAIL preload_score: got %h want f423f", sc); end
        convert(28'h1000001, lat, bc, bad_, sc, e, ov);
        checks++; if (lat !== 8) begin errors++; $display("FAIL range_latency: got %0d want 8", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL range_err: got %b want 1", e); end
        checks++; if (sc !== 20'd0) begin errors++; $display("FAIL range_score: got %h want 0", sc); end
        convert(28'h0999999, lat, bc, bad_, sc, e, ov);
        convert(28'h00000A0, lat, bc, bad_, sc, e, ov);
        checks++; if (lat !== 8) begin errors++; $display("FAIL nonbcd_latency: got %0d want 8", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL nonbcd_err: got %b want 1", e); end
        checks++; if (sc !== 20'd0) begin errors++; $display("FAIL nonbcd_score: got %h want 0", sc); end
    endtask

    task automatic test_back_to_back;
        int dones = 0;
        int expect_at = 8;
        logic ov = 1'b0;
        logic got = 1'b0;
        @(negedge clk);
        set_digits(28'h0012345);
        bus.start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (i == 2 || i == 11 || i == 20) set_digits(28'h9999999);
            if (i == 6 || i == 15 || i == 24) set_digits(28'h0012345);
            if (bus.busy && bus.done) ov = 1'b1;
            if (bus.done) begin
                dones++;
                checks++; if (i !== expect_at) begin errors++; $display("FAIL b2b_done_cycle: got %0d want %0d", i, expect_at); end
                checks++; if (bus.score !== 20'd12345) begin errors++; $display("FAIL b2b_score: got %0d want 12345", bus.score); end
                checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b want 0", bus.err); end
                expect_at = i + 9;
            end
        end
        bus.start = 1'b0;
        checks++; if (dones !== 3) begin errors++; $display("FAIL b2b_done_count: got %0d want 3", dones); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL b2b_busy_done_overlap: got %b want 0", ov); end
        for (int i = 0; i < 12 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                got = 1'b1;
                checks++; if (bus.score !== 20'd12345) begin errors++; $display("FAIL b2b_tail_score: got %0d want 12345", bus.score); end
            end
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL b2b_tail_done: got %b want 1", got); end
    endtask

    task automatic test_reset_mid;
        int lat, bc;
        logic bad_, e, ov;
        logic [19:0] sc;
        logic seen = 1'b0;
        @(negedge clk);
        set_digits(28'h0500000);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.score !== 20'd0) begin errors++; $display("FAIL midrst_score: got %0d want 0", bus.score); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", bus.err); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got %b want 0", seen); end
        convert(28'h0000042, lat, bc, bad_, sc, e, ov);
        checks++; if (lat !== 8) begin errors++; $display("FAIL after_rst_latency: got %0d want 8", lat); end
        checks++; if (sc !== 20'd42) begin errors++; $display("FAIL after_rst_score: got %0d want 42", sc); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL after_rst_err: got %b want 0", e); end
    endtask

    task automatic test_random;
        int lat, bc;
        logic bad_, e, ov;
        logic [19:0] sc;
        logic [3:0] d [7];
        logic [27:0] v;
        int val, p;
        logic exp_err;
        logic [19:0] exp_sc;
        for (int n = 0; n < 1000; n++) begin
            d[6] = 4'($urandom_range(0, 1));
            for (int k = 0; k < 6; k++) d[k] = 4'($urandom_range(0, 9));
            if (d[6] == 4'd1 && $urandom_range(0, 1) == 0) for (int k = 0; k < 6; k++) d[k] = 4'd0;
            v   = {d[6], d[5], d[4], d[3], d[2], d[1], d[0]};
            val = 0;
            p   = 1;
            for (int k = 0; k < 7; k++) begin
                val = val + int'(d[k]) * p;
                p   = p * 10;
            end
            exp_err = (val > 1000000);
            exp_sc  = exp_err ? 20'd0 : 20'(val);
            convert(v, lat, bc, bad_, sc, e, ov);
            checks++;
            if (lat !== 8 || sc !== exp_sc || e !== exp_err) begin
                errors++;
                $display("FAIL random_%0d digits=%h: got lat=%0d score=%0d err=%b want lat=8 score=%0d err=%b",
                         n, v, lat, sc, e, exp_sc, exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
